// File: rtl/riscv_i32c_imem_responder.sv
// riscv_i32c_imem_responder: imem fetch/write responder on a 1-cycle synchronous 32-bit SRAM.
// Optional macro RISCV_IMEM_SHORT_FETCH_EN: unaligned misses whose upper half is compressed complete early.
module riscv_i32c_imem_responder #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  clk__enable,
  input  logic                  reset_n,
  input  logic [31:0]           imem_access_req__address,
  input  logic [3:0]            imem_access_req__byte_enable,
  input  logic                  imem_access_req__write_enable,
  input  logic                  imem_access_req__read_enable,
  input  logic [31:0]           imem_access_req__write_data,
  output logic                  imem_access_resp__wait,
  output logic [31:0]           imem_access_resp__read_data,
  output logic                  sram_select,
  output logic                  sram_read_not_write,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [3:0]            sram_write_enable,
  output logic [31:0]           sram_write_data,
  input  logic [31:0]           sram_read_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_FIRST, ST_DATA, ST_MERGE} state_t;

  state_t                  r_state, w_state_next;
  logic                    r_buf_valid, w_buf_valid_next;
  logic [31:0]             r_buf_word, w_buf_word_next;
  logic [ADDR_WIDTH-1:0]   r_buf_addr, w_buf_addr_next;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_next;
  logic [ADDR_WIDTH-1:0]   w_req_word, w_req_word_inc, w_addr_inc;
  logic                    w_buf_hit;
  logic                    w_unused;

  assign w_req_word     = imem_access_req__address[ADDR_WIDTH+1:2];
  assign w_req_word_inc = w_req_word + ADDR_WIDTH'(1);
  assign w_addr_inc     = r_addr + ADDR_WIDTH'(1);
  assign w_buf_hit      = r_buf_valid && (r_buf_addr == w_req_word);
  assign w_unused       = ^{imem_access_req__address[31:ADDR_WIDTH+2], imem_access_req__address[0]};

  always_comb begin
    w_state_next                = r_state;
    w_buf_valid_next            = r_buf_valid;
    w_buf_word_next             = r_buf_word;
    w_buf_addr_next             = r_buf_addr;
    w_addr_next                 = r_addr;
    imem_access_resp__wait      = 1'b0;
    imem_access_resp__read_data = 32'h0;
    sram_select                 = 1'b0;
    sram_read_not_write         = 1'b1;
    sram_address                = w_req_word;
    sram_write_enable           = 4'h0;
    sram_write_data             = 32'h0;

    case (r_state)
      ST_IDLE: begin
        if (imem_access_req__write_enable) begin
          sram_select         = 1'b1;
          sram_read_not_write = 1'b0;
          sram_write_enable   = imem_access_req__byte_enable;
          sram_write_data     = imem_access_req__write_data;
          if (w_buf_hit) begin
            w_buf_valid_next = 1'b0;
          end
        end else if (imem_access_req__read_enable) begin
          sram_select            = 1'b1;
          imem_access_resp__wait = 1'b1;
          w_addr_next            = w_req_word;
          if (!imem_access_req__address[1]) begin
            w_state_next = ST_DATA;
          end else if (w_buf_hit) begin
            // Lower half already buffered: only the following word is needed.
            sram_address = w_req_word_inc;
            w_state_next = ST_MERGE;
          end else begin
            w_state_next = ST_FIRST;
          end
        end
      end

      ST_FIRST: begin
        w_buf_word_next        = sram_read_data;
        w_buf_addr_next        = r_addr;
        w_buf_valid_next       = 1'b1;
        sram_select            = 1'b1;
        sram_address           = w_addr_inc;
        imem_access_resp__wait = 1'b1;
        w_state_next           = ST_MERGE;
`ifdef RISCV_IMEM_SHORT_FETCH_EN
        if (sram_read_data[17:16] != 2'b11) begin
          sram_select                 = 1'b0;
          imem_access_resp__wait      = 1'b0;
          imem_access_resp__read_data = {16'h0, sram_read_data[31:16]};
          w_state_next                = ST_IDLE;
        end
`endif
      end

      ST_DATA: begin
        imem_access_resp__read_data = sram_read_data;
        w_buf_word_next             = sram_read_data;
        w_buf_addr_next             = r_addr;
        w_buf_valid_next            = 1'b1;
        w_state_next                = ST_IDLE;
      end

      ST_MERGE: begin
        imem_access_resp__read_data = {sram_read_data[15:0], r_buf_word[31:16]};
        w_buf_word_next             = sram_read_data;
        w_buf_addr_next             = w_addr_inc;
        w_buf_valid_next            = 1'b1;
        w_state_next                = ST_IDLE;
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_buf_valid <= 1'b0;
      r_buf_word  <= 32'h0;
      r_buf_addr  <= '0;
      r_addr      <= '0;
    end else if (clk__enable) begin
      r_state     <= w_state_next;
      r_buf_valid <= w_buf_valid_next;
      r_buf_word  <= w_buf_word_next;
      r_buf_addr  <= w_buf_addr_next;
      r_addr      <= w_addr_next;
    end
  end

endmodule

// File: doc/riscv_i32c_imem_responder.md
Name: riscv_i32c_imem_responder

Overview:
- Memory-side responder for the riscv_minimal imem_access_req/imem_access_resp interface.
- Converts core fetches into accesses on a single-port synchronous 32-bit SRAM (1-cycle read latency), signalling wait states through imem_access_resp__wait.
- Handles 16-bit-aligned fetches for i32c by merging two consecutive SRAM words, using a one-word line buffer to skip the re-read on sequential fetch.
- Supports aligned word writes with byte enables, used by program loaders.

Parameters:
ADDR_WIDTH, 14, SRAM word-address width; address word index = imem_access_req__address[ADDR_WIDTH+1:2]

Ports:
clk  input  1  clock
clk__enable  input  1  clock enable; all state advances only when high
reset_n  input  1  asynchronous active-low reset
imem_access_req__address  input  32  byte address from core
imem_access_req__byte_enable  input  4  write byte enables
imem_access_req__write_enable  input  1  write request
imem_access_req__read_enable  input  1  fetch request
imem_access_req__write_data  input  32  write data
imem_access_resp__wait  output  1  high: core must hold request stable
imem_access_resp__read_data  output  32  fetch data, valid when read completes
sram_select  output  1  SRAM access this cycle
sram_read_not_write  output  1  1 = read, 0 = write
sram_address  output  ADDR_WIDTH  SRAM word address
sram_write_enable  output  4  per-byte write enable
sram_write_data  output  32  SRAM write data
sram_read_data  input  32  SRAM data, valid the cycle after a read select

Behaviour:
- Definitions: A = req word index; A+1 wraps modulo 2^ADDR_WIDTH. Responder outputs are combinational from state and request; state registers update on clk when clk__enable is high.
- Reset: state IDLE; line buffer invalid; buf_word = 0; buf_addr = 0; latched address = 0. With no request: wait = 0, read_data = 0, sram_select = 0.
- IDLE, write_enable high (priority over read_enable):
  - SRAM write at A with byte_enable and write_data, wait = 0; address[1:0] ignored.
  - If buffer is valid and buf_addr == A, invalidate the buffer.
  - Stay in IDLE.
- IDLE, read_enable high, address[1] = 0: latch A, SRAM read A, wait = 1, go DATA.
- IDLE, read_enable high, address[1] = 1:
  - If buffer valid and buf_addr == A: SRAM read A+1, wait = 1, go MERGE.
  - Otherwise: SRAM read A, wait = 1, go FIRST.
- FIRST:
  - Load buf_word = sram_read_data, buf_addr = A, valid.
  - SRAM read A+1, wait = 1, go MERGE.
- DATA:
  - wait = 0; read_data = sram_read_data.
  - Load buffer with sram_read_data at A; go IDLE.
- MERGE:
  - wait = 0; read_data = {sram_read_data[15:0], buf_word[31:16]}.
  - Load buffer with sram_read_data at A+1; go IDLE.
- Latency: aligned fetch 2 cycles; unaligned fetch with buffer hit 2 cycles, miss 3 cycles. A new request is accepted in the cycle after completion; no back-to-back overlap.
- address[0] is ignored for reads.
- Request inputs are not re-sampled after IDLE; the latched A is used throughout the operation.
- clk__enable low: state and outputs are frozen; SRAM select is still driven from the current state.
- Asynchronous reset mid-operation: return to IDLE and invalidate the buffer; any pending SRAM data is discarded.

Optional Feature:
- Macro: RISCV_IMEM_SHORT_FETCH_EN.
- Defined: in FIRST, if sram_read_data[17:16] != 2'b11 (the upper half is a compressed instruction), complete in that cycle:
  - wait = 0; read_data = {16'h0, sram_read_data[31:16]}.
  - Load the buffer as usual; skip MERGE; go IDLE.
- Undefined: FIRST always proceeds to MERGE.

Test Plan:
- Reset, then read addr 0x0, SRAM[0] = 0x00500093 -> wait = 1 for one cycle; next cycle wait = 0, read_data = 0x00500093; 2 cycles total.
- Unaligned miss: buffer invalid, read addr 0x6, SRAM[1] = 0xAAAA1111, SRAM[2] = 0x2222BBBB -> reads of words 1 then 2; completes in cycle 3 with read_data = 0xBBBBAAAA.
- Sequential hit: read addr 0x4, then read addr 0x6 -> second fetch issues only a read of word 2 and completes in 2 cycles with the merged value.
- Write: write addr 0x4, byte_enable 4'b0011, data 0x12345678, with buffer holding word 1 -> wait = 0, sram_write_enable = 4'b0011, buffer invalidated; next read 0x6 takes 3 cycles.
- Wrap: read address (2^ADDR_WIDTH - 1)*4 + 2 -> second SRAM read at word 0; merged data correct.
- Reset asserted while in FIRST -> state IDLE, sram_select = 0, buffer invalid; a following aligned read completes normally in 2 cycles.
